mfp_irq_ctrl: RTL and testbench

//   Interrupt arbiter for the MFP: collects one-cycle event strobes from the four
//   mfp_timer instances and the GPIP/USART sources, latches them in pending

---
 rtl/mfp_irq_pkg.sv | 37 +++
 rtl/mfp_prio_enc16.sv | 19 +
 rtl/mfp_irq_ctrl.sv | 131 +++++++++++++
 tb/tb_mfp_irq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_irq_pkg.sv
// rtl/mfp_irq_pkg.sv - shared constants, FSM state type and register bank helper for the MFP interrupt arbiter
package mfp_irq_pkg;

    localparam int NSRC = 16;

    localparam logic [3:0] ADDR_IERA = 4'd0;
    localparam logic [3:0] ADDR_IERB = 4'd1;
    localparam logic [3:0] ADDR_IPRA = 4'd2;
    localparam logic [3:0] ADDR_IPRB = 4'd3;
    localparam logic [3:0] ADDR_ISRA = 4'd4;
    localparam logic [3:0] ADDR_ISRB = 4'd5;
    localparam logic [3:0] ADDR_IMRA = 4'd6;
    localparam logic [3:0] ADDR_IMRB = 4'd7;
    localparam logic [3:0] ADDR_VR   = 4'd8;

    localparam int VR_S_BIT    = 3;
    localparam int VR_BASE_LSB = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VEC  = 2'd1,
        WAIT = 2'd2
    } irq_state_t;

    // Bank A occupies bits [15:8] at the even address, bank B bits [7:0] at the next one.
    function automatic logic [15:0] bank_mask(input logic wr, input logic [3:0] addr,
                                              input logic [3:0] addr_a);
        if (!wr)
            return 16'h0000;
        if (addr == addr_a)
            return 16'hFF00;
        if (addr == addr_a + 4'd1)
            return 16'h00FF;
        return 16'h0000;
    endfunction

endpackage

// File: rtl/mfp_prio_enc16.sv
// rtl/mfp_prio_enc16.sv - 16-bit priority encoder, highest set bit wins
module mfp_prio_enc16 (
    input  logic [15:0] i_req,
    output logic        o_valid,
    output logic [3:0]  o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/mfp_irq_ctrl.sv
// rtl/mfp_irq_ctrl.sv - MFP interrupt arbiter: IE/IP/IS/IM registers, IRQ prioritisation, IACK vectoring
module mfp_irq_ctrl #(
    parameter int         NSRC     = 16,
    parameter logic [7:0] VR_RESET = 8'h00
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            SEL,
    input  logic            WE,
    input  logic [3:0]      ADDR,
    input  logic [7:0]      DAT_I,
    output logic [7:0]      DAT_O,
    input  logic [NSRC-1:0] SRC_PULSE,
    input  logic            IACK,
    output logic            IRQ_N,
    output logic [7:0]      VEC_O,
    output logic            VEC_VALID
);
    import mfp_irq_pkg::*;

    logic [NSRC-1:0] r_ie, r_ip, r_is, r_im;
    logic [7:3]      r_vr;
    logic            r_iack_d;
    logic            r_irq_n;
    logic [7:0]      r_vec_o;
    logic            r_vec_valid;
    irq_state_t      r_state, w_state_next;

    logic            w_wr, w_s, w_cand_valid, w_is_valid, w_ack_fire, w_irq_req;
    logic [3:0]      w_cand_idx, w_is_idx;
    logic [NSRC-1:0] w_wdat, w_ier_m, w_ipr_m, w_isr_m, w_imr_m;
    logic [NSRC-1:0] w_ier_clr, w_ipr_clr, w_isr_clr, w_ack_bit, w_set;

    mfp_prio_enc16 u_cand_enc (
        .i_req   (r_ip & r_im),
        .o_valid (w_cand_valid),
        .o_idx   (w_cand_idx)
    );

    mfp_prio_enc16 u_is_enc (
        .i_req   (r_is),
        .o_valid (w_is_valid),
        .o_idx   (w_is_idx)
    );

    assign w_wr      = SEL & WE;
    assign w_s       = r_vr[VR_S_BIT];
    assign w_wdat    = {DAT_I, DAT_I};
    assign w_ier_m   = bank_mask(w_wr, ADDR, ADDR_IERA);
    assign w_ipr_m   = bank_mask(w_wr, ADDR, ADDR_IPRA);
    assign w_isr_m   = bank_mask(w_wr, ADDR, ADDR_ISRA);
    assign w_imr_m   = bank_mask(w_wr, ADDR, ADDR_IMRA);
    assign w_ier_clr = w_ier_m & ~w_wdat;
    assign w_ipr_clr = w_ipr_m & ~w_wdat;
    assign w_isr_clr = w_isr_m & ~w_wdat;
    assign w_ack_bit = w_ack_fire ? (16'h0001 << w_cand_idx) : '0;
    assign w_set     = SRC_PULSE & r_ie;

    // In software-EOI mode a candidate only interrupts if it outranks everything in service.
    assign w_irq_req = w_cand_valid && (!w_s || !w_is_valid || (w_cand_idx > w_is_idx));

    always_comb begin
        w_state_next = r_state;
        w_ack_fire   = 1'b0;
        case (r_state)
            IDLE: if (IACK && !r_iack_d) w_state_next = VEC;
            VEC: begin
                w_ack_fire   = w_cand_valid;
                w_state_next = WAIT;
            end
            WAIT: if (!IACK) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    // Same-bit collisions: a pulse beats IPR/ACK clears, an IER disable beats the pulse,
    // and an ACK set beats an ISR clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ie        <= '0;
            r_ip        <= '0;
            r_is        <= '0;
            r_im        <= '0;
            r_vr        <= VR_RESET[7:3];
            r_iack_d    <= 1'b0;
            r_irq_n     <= 1'b1;
            r_vec_o     <= 8'h00;
            r_vec_valid <= 1'b0;
        end else begin
            r_ie        <= (r_ie & ~w_ier_m) | (w_wdat & w_ier_m);
            r_im        <= (r_im & ~w_imr_m) | (w_wdat & w_imr_m);
            r_ip        <= ((r_ip & ~w_ipr_clr & ~w_ack_bit) | w_set) & ~w_ier_clr;
            r_is        <= w_s ? ((r_is & ~w_isr_clr) | w_ack_bit) : '0;
            r_iack_d    <= IACK;
            r_irq_n     <= ~w_irq_req;
            r_vec_valid <= w_ack_fire;
            if (w_wr && (ADDR == ADDR_VR))
                r_vr <= DAT_I[7:3];
            if (w_ack_fire)
                r_vec_o <= {r_vr[7:VR_BASE_LSB], w_cand_idx};
        end
    end

    always_comb begin
        DAT_O = 8'h00;
        case (ADDR)
            ADDR_IERA: DAT_O = r_ie[15:8];
            ADDR_IERB: DAT_O = r_ie[7:0];
            ADDR_IPRA: DAT_O = r_ip[15:8];
            ADDR_IPRB: DAT_O = r_ip[7:0];
            ADDR_ISRA: DAT_O = r_is[15:8];
            ADDR_ISRB: DAT_O = r_is[7:0];
            ADDR_IMRA: DAT_O = r_im[15:8];
            ADDR_IMRB: DAT_O = r_im[7:0];
            ADDR_VR:   DAT_O = {r_vr, 3'b000};
            default:   DAT_O = 8'h00;
        endcase
    end

    assign IRQ_N     = r_irq_n;
    assign VEC_O     = r_vec_o;
    assign VEC_VALID = r_vec_valid;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// tb/tb_mfp_irq_ctrl.sv - self-checking bench for mfp_irq_ctrl against a per-source behavioural model
module tb_mfp_irq_ctrl;

    logic        CLK = 1'b0;
    logic        RST, SEL, WE, IACK;
    logic [3:0]  ADDR;
    logic [7:0]  DAT_I, DAT_O, VEC_O;
    logic [15:0] SRC_PULSE;
    logic        IRQ_N, VEC_VALID;

    int checks = 0;
    int errors = 0;
    int vcount;

    bit         m_ie[16], m_ip[16], m_is[16], m_im[16];
    logic [7:0] m_vr, m_vec_o;
    int         m_phase;
    bit         m_iack_prev, m_irq_n, m_vec_valid;

    always #5 CLK = ~CLK;

    mfp_irq_ctrl #(.NSRC(16), .VR_RESET(8'h00)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SEL       (SEL),
        .WE        (WE),
        .ADDR      (ADDR),
        .DAT_I     (DAT_I),
        .DAT_O     (DAT_O),
        .SRC_PULSE (SRC_PULSE),
        .IACK      (IACK),
        .IRQ_N     (IRQ_N),
        .VEC_O     (VEC_O),
        .VEC_VALID (VEC_VALID)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [3:0] a);
        logic [7:0] v;
        int base;
        v = 8'h00;
        base = (a[0] == 1'b0) ? 8 : 0;
        for (int k = 0; k < 8; k++) begin
            case (a)
                4'd0, 4'd1: v[k] = m_ie[base + k];
                4'd2, 4'd3: v[k] = m_ip[base + k];
                4'd4, 4'd5: v[k] = m_is[base + k];
                4'd6, 4'd7: v[k] = m_im[base + k];
                default:    v[k] = 1'b0;
            endcase
        end
        if (a == 4'd8)
            v = m_vr & 8'hF8;
        return v;
    endfunction

    task automatic model_step();
        int cand, top_is, off;
        bit s, fire, d, wr, ack_here;
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                m_ie[i] = 0; m_ip[i] = 0; m_is[i] = 0; m_im[i] = 0;
            end
            m_vr = 8'h00; m_phase = 0; m_iack_prev = 0;
            m_irq_n = 1; m_vec_o = 8'h00; m_vec_valid = 0;
            return;
        end
        cand = -1;
        top_is = -1;
        for (int i = 0; i < 16; i++) begin
            if (m_ip[i] && m_im[i]) cand = i;
            if (m_is[i]) top_is = i;
        end
        s = m_vr[3];
        fire = (m_phase == 1) && (cand >= 0);
        m_irq_n = !((cand >= 0) && (!s || cand > top_is));
        m_vec_valid = fire;
        if (fire)
            m_vec_o = {m_vr[7:4], 4'(cand)};
        wr = SEL && WE;
        for (int i = 0; i < 16; i++) begin
            d = DAT_I[i % 8];
            off = (i >= 8) ? 0 : 1;
            ack_here = fire && (i == cand);
            if (wr && ADDR == 4'(2 + off) && !d) m_ip[i] = 0;
            if (ack_here) m_ip[i] = 0;
            if (SRC_PULSE[i] && m_ie[i]) m_ip[i] = 1;
            if (wr && ADDR == 4'(0 + off) && !d) m_ip[i] = 0;
            if (wr && ADDR == 4'(4 + off) && !d) m_is[i] = 0;
            if (ack_here && s) m_is[i] = 1;
            if (!s) m_is[i] = 0;
            if (wr && ADDR == 4'(0 + off)) m_ie[i] = d;
            if (wr && ADDR == 4'(6 + off)) m_im[i] = d;
        end
        if (wr && ADDR == 4'd8)
            m_vr = DAT_I & 8'hF8;
        case (m_phase)
            0: if (IACK && !m_iack_prev) m_phase = 1;
            1: m_phase = 2;
            default: if (!IACK) m_phase = 0;
        endcase
        m_iack_prev = IACK;
    endtask

    task automatic tick();
        #1;
        check("dat_o", DAT_O, model_read(ADDR));
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check("irq_n", IRQ_N, m_irq_n);
        check("vec_valid", VEC_VALID, m_vec_valid);
        check("vec_o", VEC_O, m_vec_o);
    endtask

    task automatic idle();
        SEL = 0; WE = 0; SRC_PULSE = 16'h0000;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        SEL = 1; WE = 1; ADDR = a; DAT_I = d;
        tick();
        SEL = 0; WE = 0;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        ADDR = a;
        #1;
        check(tag, DAT_O, exp);
    endtask

    task automatic do_reset();
        idle(); IACK = 0; RST = 1;
        tick();
        RST = 0;
    endtask

    task automatic setup_13_4(input logic [7:0] vr);
        wr(4'd8, vr);
        wr(4'd0, 8'h20); wr(4'd6, 8'h20);
        wr(4'd1, 8'h10); wr(4'd7, 8'h10);
        SRC_PULSE = 16'h2010;
        tick();
        SRC_PULSE = 16'h0000;
    endtask

    initial begin
        RST = 1; SEL = 0; WE = 0; ADDR = 4'd0; DAT_I = 8'h00; SRC_PULSE = 16'h0000; IACK = 0;
        @(negedge CLK);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        RST = 0;
        check("rst_irq_n", IRQ_N, 1'b1);
        check("rst_vec_valid", VEC_VALID, 1'b0);
        check("rst_vec_o", VEC_O, 8'h00);
        rd_check("rst_vr", 4'd8, 8'h00);

        // pulse to IRQ latency
        wr(4'd0, 8'h20); wr(4'd6, 8'h20);
        SRC_PULSE = 16'h2000;
        tick();
        SRC_PULSE = 16'h0000;
        rd_check("t1_ipra", 4'd2, 8'h20);
        check("t1_irq_n_n1", IRQ_N, 1'b1);
        tick();
        check("t1_irq_n_n2", IRQ_N, 1'b0);

        // software EOI vectoring
        do_reset();
        setup_13_4(8'h48);
        IACK = 1;
        tick();
        tick();
        check("t2_vv", VEC_VALID, 1'b1);
        check("t2_vec", VEC_O, 8'h4D);
        tick();
        check("t2_vv_once", VEC_VALID, 1'b0);
        check("t2_irq_hi", IRQ_N, 1'b1);
        rd_check("t2_isra", 4'd4, 8'h20);
        IACK = 0;
        tick();
        wr(4'd4, 8'hDF);
        tick();
        check("t2_irq_lo", IRQ_N, 1'b0);
        IACK = 1;
        tick();
        tick();
        check("t2_vv2", VEC_VALID, 1'b1);
        check("t2_vec2", VEC_O, 8'h44);
        IACK = 0;
        tick();

        // auto EOI, pulse during ACK re-requests
        do_reset();
        wr(4'd8, 8'h40); wr(4'd1, 8'h20); wr(4'd7, 8'h20);
        SRC_PULSE = 16'h0020;
        tick();
        SRC_PULSE = 16'h0000;
        IACK = 1;
        tick();
        SRC_PULSE = 16'h0020;
        tick();
        SRC_PULSE = 16'h0000;
        check("t3_vv", VEC_VALID, 1'b1);
        check("t3_vec", VEC_O, 8'h45);
        rd_check("t3_isrb", 4'd5, 8'h00);
        rd_check("t3_iprb", 4'd3, 8'h20);
        IACK = 0;
        tick();

        // disabled drop, set-vs-clear collisions
        do_reset();
        SRC_PULSE = 16'h0001;
        tick();
        SRC_PULSE = 16'h0000;
        rd_check("t4_drop", 4'd3, 8'h00);
        wr(4'd1, 8'h01);
        SEL = 1; WE = 1; ADDR = 4'd3; DAT_I = 8'hFE; SRC_PULSE = 16'h0001;
        tick();
        idle();
        rd_check("t4_set_wins", 4'd3, 8'h01);
        SEL = 1; WE = 1; ADDR = 4'd1; DAT_I = 8'h00; SRC_PULSE = 16'h0001;
        tick();
        idle();
        rd_check("t4_ier_wins", 4'd3, 8'h00);

        // held IACK vectors once; empty IACK vectors nothing
        do_reset();
        setup_13_4(8'h48);
        IACK = 1;
        vcount = 0;
        repeat (20) begin
            tick();
            if (VEC_VALID) vcount++;
        end
        check("t5_one_vec", 16'(vcount), 16'd1);
        IACK = 0;
        tick();
        wr(4'd2, 8'h00); wr(4'd3, 8'h00); wr(4'd4, 8'h00);
        IACK = 1;
        vcount = 0;
        repeat (6) begin
            tick();
            if (VEC_VALID) vcount++;
        end
        check("t5_no_vec", 16'(vcount), 16'd0);
        IACK = 0;
        tick();
        SRC_PULSE = 16'h0010;
        tick();
        SRC_PULSE = 16'h0000;
        IACK = 1;
        tick();
        tick();
        check("t5_back_idle", VEC_VALID, 1'b1);
        check("t5_vec", VEC_O, 8'h44);
        IACK = 0;
        tick();

        // reset in VEC aborts the ACK
        do_reset();
        setup_13_4(8'h48);
        IACK = 1;
        tick();
        RST = 1;
        tick();
        RST = 0;
        check("t6_vv", VEC_VALID, 1'b0);
        check("t6_irq_n", IRQ_N, 1'b1);
        rd_check("t6_vr", 4'd8, 8'h00);
        rd_check("t6_iera", 4'd0, 8'h00);
        rd_check("t6_ipra", 4'd2, 8'h00);
        IACK = 0;
        tick();

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            RST       = ($urandom_range(0, 299) == 0);
            SEL       = ($urandom_range(0, 3) == 0);
            WE        = 1'($urandom);
            ADDR      = 4'($urandom_range(0, 10));
            DAT_I     = 8'($urandom);
            SRC_PULSE = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 5) == 0)
                IACK = ~IACK;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
